// File: rtl/sound_arbiter_pkg.sv
// sound_arbiter_pkg: shared state encoding, tone indices, half-period and jingle tables.
package sound_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LEVEL = 2'd1, J_NOTE = 2'd2, J_GAP = 2'd3} state_e;
  typedef enum logic [1:0] {JNG_START = 2'd0, JNG_WIN = 2'd1, JNG_LOSE = 2'd2, JNG_HS = 2'd3} jingle_e;
  localparam logic [2:0] TONE_OFF = 3'd0;
  // Index 0 is silence and never counted against; its entry only has to be legal.
  localparam logic [15:0] HALF_PER [8] = '{16'd2, 16'd40, 16'd36, 16'd32, 16'd30, 16'd26, 16'd22, 16'd18};
  localparam logic [2:0] JINGLE [4][4] = '{
    '{3'd1, 3'd2, 3'd3, 3'd4},
    '{3'd4, 3'd5, 3'd6, 3'd7},
    '{3'd7, 3'd3, 3'd2, 3'd1},
    '{3'd7, 3'd5, 3'd7, 3'd6}
  };
  function automatic logic [2:0] color_tone(input logic [1:0] c);
    return {1'b1, c};
  endfunction
endpackage

// File: rtl/sound_arbiter_tone_gen.sv
// sound_arbiter_tone_gen: square-wave generator whose phase restarts on every tone change.
module sound_arbiter_tone_gen
  import sound_arbiter_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] tone_i,
  output logic       spk_o
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  logic [DIV_W-1:0] cnt_q, cnt_d, half;
  logic [2:0] prev_q;
  logic spk_q, spk_d, hold, wrap;
  assign half = DIV_W'(HALF_PER[tone_i]);
  assign hold = (tone_i != TONE_OFF) && (tone_i == prev_q);
  assign wrap = cnt_q == half - ONE;
  always_comb begin
    cnt_d = (hold && !wrap) ? cnt_q + ONE : '0;
    spk_d = hold && (spk_q ^ wrap);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      spk_q  <= 1'b0;
      prev_q <= TONE_OFF;
    end else begin
      cnt_q  <= cnt_d;
      spk_q  <= spk_d;
      prev_q <= tone_i;
    end
  end
  // Mask the stale phase in the cycle a new tone first appears.
  assign spk_o = spk_q && hold;
endmodule

// File: rtl/sound_arbiter.sv
// sound_arbiter: prioritises jingle, press and display tones and drives the speaker.
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int NOTE_TICKS = 150,
  parameter int GAP_TICKS  = 30
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] disp_color_i,
  input  logic       disp_ena_i,
  input  logic [1:0] press_color_i,
  input  logic       press_valid_i,
  input  logic       evt_start_i,
  input  logic       evt_win_i,
  input  logic       evt_lose_i,
  input  logic       evt_hs_i,
  input  logic       tick_i,
  output logic       spk_o,
  output logic       busy_o,
  output logic [2:0] tone_o
);
  localparam logic [7:0] NOTE_LAST = 8'(NOTE_TICKS - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);
  state_e state_q, state_d, lvl_state;
  jingle_e jng_q, jng_d, evt_sel;
  logic [1:0] note_q, note_d;
  logic [7:0] tick_q, tick_d;
  logic [2:0] tone_q, tone_d, lvl_tone;
  logic evt_any, tick_done;
  assign evt_any   = evt_start_i | evt_win_i | evt_lose_i | evt_hs_i;
  assign evt_sel   = evt_lose_i ? JNG_LOSE : evt_win_i ? JNG_WIN : evt_hs_i ? JNG_HS : JNG_START;
  assign lvl_state = (press_valid_i || disp_ena_i) ? LEVEL : IDLE;
  assign lvl_tone  = press_valid_i ? color_tone(press_color_i) :
                     disp_ena_i    ? color_tone(disp_color_i)  : TONE_OFF;
  assign tick_done = tick_i && (tick_q == ((state_q == J_NOTE) ? NOTE_LAST : GAP_LAST));
  always_comb begin
    state_d = state_q;
    jng_d   = jng_q;
    note_d  = note_q;
    tick_d  = tick_q + {7'd0, tick_i};
    tone_d  = tone_q;
    if (state_q == J_NOTE) begin
      if (tick_done) begin
        state_d = J_GAP;
        tick_d  = '0;
        tone_d  = TONE_OFF;
      end
    end else if (state_q == J_GAP) begin
      if (tick_done) begin
        tick_d = '0;
        if (note_q == 2'd3) begin
          state_d = lvl_state;
          tone_d  = lvl_tone;
        end else begin
          state_d = J_NOTE;
          note_d  = note_q + 2'd1;
          tone_d  = JINGLE[jng_q][note_q + 2'd1];
        end
      end
    end else if (evt_any) begin
      state_d = J_NOTE;
      jng_d   = evt_sel;
      note_d  = '0;
      tick_d  = '0;
      tone_d  = JINGLE[evt_sel][0];
    end else begin
      state_d = lvl_state;
      tick_d  = '0;
      tone_d  = lvl_tone;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      jng_q   <= JNG_START;
      note_q  <= '0;
      tick_q  <= '0;
      tone_q  <= TONE_OFF;
    end else begin
      state_q <= state_d;
      jng_q   <= jng_d;
      note_q  <= note_d;
      tick_q  <= tick_d;
      tone_q  <= tone_d;
    end
  end
  assign busy_o = (state_q == J_NOTE) || (state_q == J_GAP);
  assign tone_o = tone_q;
  sound_arbiter_tone_gen #(.DIV_W(DIV_W)) u_tone_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tone_i (tone_q),
    .spk_o  (spk_o)
  );
endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: randomized and directed checks against a segment-queue reference model.
module tb_sound_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] disp_color = '0, press_color = '0;
  logic disp_ena = 1'b0, press_valid = 1'b0, tick = 1'b0;
  logic evt_start = 1'b0, evt_win = 1'b0, evt_lose = 1'b0, evt_hs = 1'b0;
  logic spk, busy;
  logic [2:0] tone;
  always #5 clk = ~clk;
  sound_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .disp_color_i(disp_color), .disp_ena_i(disp_ena),
    .press_color_i(press_color), .press_valid_i(press_valid), .evt_start_i(evt_start),
    .evt_win_i(evt_win), .evt_lose_i(evt_lose), .evt_hs_i(evt_hs), .tick_i(tick),
    .spk_o(spk), .busy_o(busy), .tone_o(tone)
  );
  int half_per [8] = '{2, 40, 36, 32, 30, 26, 22, 18};
  int jingle [4][4] = '{'{1, 2, 3, 4}, '{4, 5, 6, 7}, '{7, 3, 2, 1}, '{7, 5, 7, 6}};
  int seg_tone[$], seg_left[$];
  int m_tone = 0, m_age = 0, checks = 0, failures = 0, tick_cnt;
  bit m_busy = 0, m_spk = 0;
  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  // One upcoming clock edge as seen by the rules: a jingle is a list of timed segments.
  task automatic model_step();
    int j, nt;
    if (seg_left.size() != 0) begin
      if (tick) begin
        seg_left[0] = seg_left[0] - 1;
        if (seg_left[0] == 0) begin
          void'(seg_left.pop_front());
          void'(seg_tone.pop_front());
        end
      end
    end else if (evt_start || evt_win || evt_lose || evt_hs) begin
      j = evt_lose ? 2 : evt_win ? 1 : evt_hs ? 3 : 0;
      for (int n = 0; n < 4; n++) begin
        seg_tone.push_back(jingle[j][n]); seg_left.push_back(150);
        seg_tone.push_back(0);            seg_left.push_back(30);
      end
    end
    nt = seg_tone.size() != 0 ? seg_tone[0] :
         press_valid ? 4 + int'(press_color) : disp_ena ? 4 + int'(disp_color) : 0;
    m_age  = (nt != m_tone) ? 0 : m_age + 1;
    m_tone = nt;
    m_busy = seg_tone.size() != 0;
    m_spk  = m_tone != 0 && m_age >= 1 && (((m_age - 1) / half_per[m_tone]) % 2 == 1);
  endtask
  task automatic cycle();
    model_step();
    @(negedge clk);
    check_eq("tone", int'(tone), m_tone);
    check_eq("busy", int'(busy), int'(m_busy));
    check_eq("spk", int'(spk), int'(m_spk));
  endtask
  task automatic finish_jingle(input string tag);
    for (int i = 0; i < 4000 && busy; i++) begin
      tick = 1'b1;
      cycle();
    end
    tick = 1'b0;
    check_eq(tag, int'(busy), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_tone", int'(tone), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_spk", int'(spk), 0);
    rst_n = 1'b1;
    disp_ena = 1'b1; disp_color = 2'd2;
    cycle();
    check_eq("disp_tone6", int'(tone), 6);
    repeat (999) cycle();
    disp_ena = 1'b0;
    cycle();
    check_eq("disp_off_tone", int'(tone), 0);
    check_eq("disp_off_spk", int'(spk), 0);
    disp_ena = 1'b1; disp_color = 2'd1; press_valid = 1'b1; press_color = 2'd3;
    cycle();
    check_eq("press_over_disp", int'(tone), 7);
    press_valid = 1'b0;
    cycle();
    check_eq("disp_after_press", int'(tone), 5);
    disp_ena = 1'b0;
    repeat (3) cycle();
    evt_win = 1'b1; evt_start = 1'b1; tick = 1'($urandom % 2);
    cycle();
    evt_win = 1'b0; evt_start = 1'b0;
    check_eq("win_note0", int'(tone), 4);
    tick_cnt = 0;
    for (int i = 0; i < 5000 && busy; i++) begin
      tick = 1'($urandom % 2);
      evt_lose = (i == 700);
      if (tick) tick_cnt++;
      cycle();
    end
    evt_lose = 1'b0; tick = 1'b0;
    check_eq("win_busy_ticks", tick_cnt, 720);
    check_eq("win_done", int'(busy), 0);
    evt_start = 1'b1; tick = 1'b1;
    cycle();
    evt_start = 1'b0;
    repeat (149) cycle();
    check_eq("note_len_149", int'(tone), 1);
    cycle();
    check_eq("note_len_150", int'(tone), 0);
    finish_jingle("start_done");
    press_valid = 1'b1; press_color = 2'd2;
    repeat (2) cycle();
    evt_lose = 1'b1;
    cycle();
    evt_lose = 1'b0;
    check_eq("lose_preempt", int'(tone), 7);
    finish_jingle("lose_done");
    check_eq("lose_back_press", int'(tone), 6);
    press_valid = 1'b0;
    cycle();
    evt_hs = 1'b1;
    cycle();
    evt_hs = 1'b0;
    for (int i = 0; i < 1000 && seg_left.size() > 4; i++) begin
      tick = 1'b1;
      cycle();
    end
    tick = 1'b1;
    repeat (20) cycle();
    tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_tone", int'(tone), 0);
    check_eq("async_rst_busy", int'(busy), 0);
    check_eq("async_rst_spk", int'(spk), 0);
    seg_tone.delete(); seg_left.delete();
    m_tone = 0; m_age = 0; m_busy = 0; m_spk = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick = 1'($urandom % 2);
      cycle();
    end
    for (int i = 0; i < 8000; i++) begin
      if (i % 64 == 0) begin
        disp_ena = 1'($urandom % 2); disp_color = 2'($urandom);
        press_valid = 1'($urandom % 3 == 0); press_color = 2'($urandom);
      end
      tick = 1'($urandom % 2);
      {evt_lose, evt_win, evt_hs, evt_start} = ($urandom % 400 == 0) ? 4'($urandom) : 4'd0;
      cycle();
    end
    {evt_lose, evt_win, evt_hs, evt_start} = 4'd0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
